// File: rtl/video_timing_gen_pkg.sv
// Shared raster timing constants and helpers for video_timing_gen and the pixel generators.
// Counter coordinates are raw: sync, back porch, active, front porch, counted from 0.
package video_timing_gen_pkg;

  typedef struct packed {
    int width;
    int height;
    int hSync;
    int hFPorch;
    int hBPorch;
    int vSync;
    int vFPorch;
    int vBPorch;
  } timing_t;

  localparam timing_t TIMING_1080P = '{
    width: 1920, height: 1080,
    hSync: 44, hFPorch: 88, hBPorch: 148,
    vSync: 5,  vFPorch: 4,  vBPorch: 36
  };

  localparam timing_t TIMING_720P = '{
    width: 1280, height: 720,
    hSync: 40, hFPorch: 110, hBPorch: 220,
    vSync: 5,  vFPorch: 5,   vBPorch: 20
  };

  function automatic int calcTotal(input int sync, input int bPorch, input int active,
                                   input int fPorch);
    return sync + bPorch + active + fPorch;
  endfunction

  function automatic int calcActStart(input int sync, input int bPorch, input int border);
    return sync + bPorch + border;
  endfunction

  function automatic int calcActEnd(input int sync, input int bPorch, input int active,
                                    input int border);
    return sync + bPorch + active - border - 1;
  endfunction

  localparam int H_TOTAL_1080P = calcTotal(TIMING_1080P.hSync, TIMING_1080P.hBPorch,
                                           TIMING_1080P.width, TIMING_1080P.hFPorch);
  localparam int V_TOTAL_1080P = calcTotal(TIMING_1080P.vSync, TIMING_1080P.vBPorch,
                                           TIMING_1080P.height, TIMING_1080P.vFPorch);
  localparam int HA0_1080P = calcActStart(TIMING_1080P.hSync, TIMING_1080P.hBPorch, 0);
  localparam int HA1_1080P = calcActEnd(TIMING_1080P.hSync, TIMING_1080P.hBPorch,
                                        TIMING_1080P.width, 0);
  localparam int VA0_1080P = calcActStart(TIMING_1080P.vSync, TIMING_1080P.vBPorch, 0);
  localparam int VA1_1080P = calcActEnd(TIMING_1080P.vSync, TIMING_1080P.vBPorch,
                                        TIMING_1080P.height, 0);

  localparam int H_TOTAL_720P = calcTotal(TIMING_720P.hSync, TIMING_720P.hBPorch,
                                          TIMING_720P.width, TIMING_720P.hFPorch);
  localparam int V_TOTAL_720P = calcTotal(TIMING_720P.vSync, TIMING_720P.vBPorch,
                                          TIMING_720P.height, TIMING_720P.vFPorch);

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping 16-bit counter with sync and active-window decode.
// Flags are decoded from the next count so the parent can register them alongside it.
module timing_axis #(
  parameter int TOTAL = 2200,
  parameter int SYNC  = 44,
  parameter int ACT0  = 192,
  parameter int ACT1  = 2111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] count,
  output logic        wrap,
  output logic        carry,
  output logic        inSyncNext,
  output logic        inActiveNext
);

  localparam logic [15:0] LAST    = 16'(TOTAL - 1);
  localparam logic [15:0] SYNCEND = 16'(SYNC);
  localparam logic [15:0] A0      = 16'(ACT0);
  localparam logic [15:0] A1      = 16'(ACT1);

  logic [15:0] countNext;

  assign carry = step && (count == LAST);

  always_comb begin
    countNext = count;
    if (step) countNext = (count == LAST) ? 16'd0 : count + 16'd1;
  end

  assign inSyncNext   = countNext < SYNCEND;
  assign inActiveNext = (countNext >= A0) && (countNext <= A1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= LAST;
      wrap  <= 1'b0;
    end else begin
      count <= countNext;
      wrap  <= carry;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: raw x/y coordinates, data enable, syncs and line/frame markers.
// Reset parks both counters on their last value so the first pix_en starts a frame at (0,0).
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int WIDTH       = 1920,
  parameter int HEIGHT      = 1080,
  parameter int H_SYNC_TIME = 44,
  parameter int V_SYNC_TIME = 5,
  parameter int H_F_PORCH   = 88,
  parameter int V_F_PORCH   = 4,
  parameter int H_B_PORCH   = 148,
  parameter int V_B_PORCH   = 36,
  parameter int H_LR_BORDER = 0,
  parameter int V_LR_BORDER = 0,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        vde,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = calcTotal(H_SYNC_TIME, H_B_PORCH, WIDTH, H_F_PORCH);
  localparam int V_TOTAL = calcTotal(V_SYNC_TIME, V_B_PORCH, HEIGHT, V_F_PORCH);
  localparam int HA0 = calcActStart(H_SYNC_TIME, H_B_PORCH, H_LR_BORDER);
  localparam int HA1 = calcActEnd(H_SYNC_TIME, H_B_PORCH, WIDTH, H_LR_BORDER);
  localparam int VA0 = calcActStart(V_SYNC_TIME, V_B_PORCH, V_LR_BORDER);
  localparam int VA1 = calcActEnd(V_SYNC_TIME, V_B_PORCH, HEIGHT, V_LR_BORDER);

  if (H_TOTAL > 65535 || V_TOTAL > 65535 ||
      2 * H_LR_BORDER >= WIDTH || 2 * V_LR_BORDER >= HEIGHT) begin : gBadParams
    $error("video_timing_gen: illegal timing parameters");
  end

  logic hCarry, hSyncNext, hActNext;
  logic vCarry, vSyncNext, vActNext;

  timing_axis #(.TOTAL(H_TOTAL), .SYNC(H_SYNC_TIME), .ACT0(HA0), .ACT1(HA1)) uHAxis (
    .clk          (clk),
    .rst          (rst),
    .step         (pix_en),
    .count        (x),
    .wrap         (line_start),
    .carry        (hCarry),
    .inSyncNext   (hSyncNext),
    .inActiveNext (hActNext)
  );

  // The vertical axis steps on the same edge the horizontal one wraps.
  timing_axis #(.TOTAL(V_TOTAL), .SYNC(V_SYNC_TIME), .ACT0(VA0), .ACT1(VA1)) uVAxis (
    .clk          (clk),
    .rst          (rst),
    .step         (hCarry),
    .count        (y),
    .wrap         (frame_start),
    .carry        (vCarry),
    .inSyncNext   (vSyncNext),
    .inActiveNext (vActNext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'hFFFF;
      vde       <= 1'b0;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
    end else begin
      if (vCarry) frame_cnt <= frame_cnt + 16'd1;
      vde   <= hActNext && vActNext;
      hsync <= hSyncNext ? HS_POL : ~HS_POL;
      vsync <= vSyncNext ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing source that drives the pixel generators. It produces the pixel coordinates (x, y), the video data enable (vde), hsync and vsync, and frame/line markers.
- Counter coordinates are raw and include sync and porch intervals. Pixel generators subtract the sync and back-porch offsets themselves.
- Sits between the pixel-clock domain and the HDMI/VGA encoder. Its x, y and vde outputs feed pixel_gen-style blocks in parallel.

Parameters:
- WIDTH, 1920, active pixels per line.
- HEIGHT, 1080, active lines per frame.
- H_SYNC_TIME, 44, hsync width in pixels.
- V_SYNC_TIME, 5, vsync width in lines.
- H_F_PORCH, 88, horizontal front porch in pixels.
- V_F_PORCH, 4, vertical front porch in lines.
- H_B_PORCH, 148, horizontal back porch in pixels.
- V_B_PORCH, 36, vertical back porch in lines.
- H_LR_BORDER, 0, pixels removed from each side of the active region (vde low there).
- V_LR_BORDER, 0, lines removed from top and bottom of the active region.
- HS_POL, 1, active level of hsync.
- VS_POL, 1, active level of vsync.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  advance enable; counters step only when high (allows a divided pixel rate)
- x  out  16  horizontal counter, 0..H_TOTAL-1
- y  out  16  vertical counter, 0..V_TOTAL-1
- vde  out  1  high inside the active (border-trimmed) region
- hsync  out  1  horizontal sync, HS_POL when active
- vsync  out  1  vertical sync, VS_POL when active
- line_start  out  1  one-cycle pulse when x enters 0
- frame_start  out  1  one-cycle pulse when (x,y) enters (0,0)
- frame_cnt  out  16  frame counter, wraps modulo 2^16

Behaviour:
- Derived totals:
  - H_TOTAL = H_SYNC_TIME + H_B_PORCH + WIDTH + H_F_PORCH (2200 by default).
  - V_TOTAL = V_SYNC_TIME + V_B_PORCH + HEIGHT + V_F_PORCH (1125 by default).
- Line order, x counted from 0: sync, back porch, active, front porch. Frame order in lines is the same.
- Horizontal active window: HA0 = H_SYNC_TIME + H_B_PORCH + H_LR_BORDER, HA1 = H_SYNC_TIME + H_B_PORCH + WIDTH - H_LR_BORDER - 1.
- Vertical active window: VA0 and VA1 are defined analogously.
- vde = (HA0 ≤ x ≤ HA1) and (VA0 ≤ y ≤ VA1).
- hsync = HS_POL when x < H_SYNC_TIME, otherwise ~HS_POL.
- vsync = VS_POL when y < V_SYNC_TIME, otherwise ~VS_POL. vsync edges therefore coincide with x = 0.
- All outputs are registered. vde, hsync and vsync always equal the decode of the x, y values presented in the same cycle (zero skew). The implementation decodes the next-state counter values.
- Stepping on a cycle with pix_en = 1:
  - If x < H_TOTAL-1, x increments.
  - Otherwise x wraps to 0, line_start is asserted, and y increments.
  - If y is also at V_TOTAL-1, y wraps to 0, frame_start is asserted, and frame_cnt increments.
- pix_en = 0: x, y, vde, hsync, vsync and frame_cnt hold their values; line_start and frame_start are 0.
- Pulses last exactly one clk cycle, even with pix_en held high continuously.
- Reset (synchronous, active-high, overrides pix_en):
  - x = H_TOTAL-1, y = V_TOTAL-1, frame_cnt = 16'hFFFF.
  - vde = 0, hsync = ~HS_POL, vsync = ~VS_POL, line_start = 0, frame_start = 0.
  - The first pix_en after reset release wraps to (0,0) with frame_start = 1 and frame_cnt = 0.
- Reset asserted mid-frame returns to the reset state on the next edge. No partial frame completes.
- Widths: counters are 16-bit. Legal parameters require H_TOTAL and V_TOTAL ≤ 65535 and 2*H_LR_BORDER < WIDTH (same for the vertical border). Elaboration fails otherwise.
- Latency: output changes appear one clk after the pix_en cycle that caused them.

Decomposition:
- Shared package/header holds:
  - localparams H_TOTAL, V_TOTAL, HA0, HA1, VA0, VA1, computed from the timing parameters.
  - Standard 1080p60 and 720p60 timing constant sets, reused by pixel generators to compute offsets.
- One sub-module: timing_axis.
  - Parameterised wrapping counter with TOTAL, SYNC and ACTIVE window bounds.
  - Inputs: step enable. Outputs: count, wrap pulse, in_sync, in_active.
  - Instantiated twice: horizontal axis stepped by pix_en, vertical axis stepped by the horizontal wrap.

Test Plan:
- Reset, then pix_en held at 1 for 2 cycles -> after reset x = 2199, y = 1124, vde = 0, hsync = vsync = 0. Cycle 1: x = 0, y = 0, frame_start = 1, line_start = 1, frame_cnt = 0, hsync = vsync = 1. Cycle 2: pulses 0.
- Horizontal sweep with defaults -> hsync = 1 for x 0..43 and falls at x = 44. On line y = 41, vde rises at x = 192 and falls after x = 2111 (1920 high cycles). line_start occurs every 2200 cycles.
- Full frame with defaults -> vsync high for y 0..4. vde is high only on lines 41..1120. Total vde-high cycles = 2,073,600. frame_start period = 2,475,000 cycles.
- pix_en asserted every other cycle -> x advances once per two clks; holds values while low; pulses never stretch beyond 1 clk; frame period doubles to 4,950,000 clks.
- Small parameters (WIDTH = 8, HEIGHT = 4, H_LR_BORDER = 2, V_LR_BORDER = 1, HS_POL = VS_POL = 0, syncs/porches = 1) -> vde high for 4 pixels × 2 lines per frame; syncs active-low; frame_cnt wraps 16'hFFFF -> 0 after 65536 frames (forced via short totals).
- rst pulsed mid-active-line (x = 500, y = 300) -> next clk x = 2199, y = 1124, vde = 0, frame_cnt = 16'hFFFF; the first step after release gives a frame_start.
